// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared types and constants for the core_ctrl instruction
// sequencer.
//   - state_e     : sequencer state encoding
//   - inst bit    : bit positions of the 19-bit core instruction word
//   - *_DEF       : default parameter values for core_ctrl
// Optional feature macro used by the top: CORE_CTRL_SFP_EN.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_QWR,
        ST_KWR,
        ST_KLD,
        ST_KGAP,
        ST_EXE,
        ST_DRN,
        ST_PWR,
        ST_SACC,
        ST_SDIV,
        ST_DONE
    } state_e;

    localparam int INST_W = 19;
    localparam int CNT_W  = 5;
    localparam int ADD_W  = 4;

    localparam int DIV        = 18;
    localparam int ACC        = 17;
    localparam int OFIFO_RD   = 16;
    localparam int QK_ADD_LSB = 12;
    localparam int P_ADD_LSB  = 8;
    localparam int EXEC       = 7;
    localparam int LOAD       = 6;
    localparam int QRD        = 5;
    localparam int QWR        = 4;
    localparam int KRD        = 3;
    localparam int KWR        = 2;
    localparam int PRD        = 1;
    localparam int PWR        = 0;

    localparam int BW_DEF        = 8;
    localparam int PR_DEF        = 16;
    localparam int COL_DEF       = 8;
    localparam int LEN_Q_DEF     = 16;
    localparam int DRAIN_CYC_DEF = 24;

endpackage

// File: rtl/ctrl_phase_cnt.sv
// ctrl_phase_cnt: 5-bit phase counter, reloaded to zero at each phase entry.
//   clk_i, rst_i : clock, async active-high reset
//   load_i       : clear to zero (wins over en_i)
//   en_i         : advance by one; saturates at lim_i
//   lim_i        : phase limit for the current phase
//   cnt_o        : current count
//   cnt_nxt_o    : value the counter takes at the next edge
//   tc_o         : count has reached lim_i
module ctrl_phase_cnt
    import core_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] lim_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o      = (cnt_q == lim_i);
    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (en_i && !tc_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: instruction sequencer for the single-core compute block. One
// start pulse streams Q/K vectors in, loads kernels, executes, drains the
// ofifo into psum memory and (optionally) runs SFP accumulate and divide.
//   clk, reset         : clock, async active-high reset
//   start              : begin a pass (sampled in IDLE only)
//   busy, done         : status; done pulses for one cycle in DONE
//   in_data/in_valid   : Q/K vector stream; in_ready high in QWR/KWR
//   inst               : 19-bit instruction word to the core
//   mem_in             : qmem/kmem write data
// Macro CORE_CTRL_SFP_EN enables the SACC/SDIV phases; when undefined PWR
// goes straight to DONE and inst[18:17] stay 0.
//
// state | meaning
// IDLE  | waiting for start
// QWR   | accept len_q Q beats into qmem
// KWR   | accept col K beats into kmem
// KLD   | read kmem and load kernels (col+2 cycles)
// KGAP  | one quiet cycle before execute
// EXE   | read qmem and execute (len_q+1 cycles)
// DRN   | wait drain_cyc cycles for the array to drain
// PWR   | ofifo -> psum memory (len_q+1 cycles)
// SACC  | SFP accumulate (len_q+1 cycles)
// SDIV  | SFP divide (len_q+1 cycles)
// DONE  | one-cycle done pulse
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int bw        = BW_DEF,
    parameter int pr        = PR_DEF,
    parameter int col       = COL_DEF,
    parameter int len_q     = LEN_Q_DEF,
    parameter int drain_cyc = DRAIN_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [pr*bw-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [INST_W-1:0] inst,
    output logic [pr*bw-1:0]  mem_in
);

    localparam logic [CNT_W-1:0] LIM_Q   = CNT_W'(len_q - 1);
    localparam logic [CNT_W-1:0] LIM_K   = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] LIM_KLD = CNT_W'(col + 1);
    localparam logic [CNT_W-1:0] LIM_RUN = CNT_W'(len_q);
    localparam logic [CNT_W-1:0] LIM_DRN = CNT_W'(drain_cyc - 1);
    localparam logic [CNT_W-1:0] COL_C   = CNT_W'(col);
    localparam logic [CNT_W-1:0] LQ_C    = CNT_W'(len_q);

    state_e              state_q, state_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [pr*bw-1:0]    mem_in_q, mem_in_d;
    logic                busy_q, done_q, in_ready_q;
    logic                cnt_load, cnt_en, cnt_tc, accept;
    logic [CNT_W-1:0]    cnt_lim, cnt, cnt_nxt, addr_v;

    ctrl_phase_cnt u_cnt (
        .clk_i     (clk),
        .rst_i     (reset),
        .load_i    (cnt_load),
        .en_i      (cnt_en),
        .lim_i     (cnt_lim),
        .cnt_o     (cnt),
        .cnt_nxt_o (cnt_nxt),
        .tc_o      (cnt_tc)
    );

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b1;
        cnt_lim  = '0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_load = 1'b1;
                if (start) state_d = ST_QWR;
            end
            ST_QWR: begin
                cnt_lim = LIM_Q;
                cnt_en  = accept;
                if (accept && cnt_tc) begin
                    state_d  = ST_KWR;
                    cnt_load = 1'b1;
                end
            end
            ST_KWR: begin
                cnt_lim = LIM_K;
                cnt_en  = accept;
                if (accept && cnt_tc) begin
                    state_d  = ST_KLD;
                    cnt_load = 1'b1;
                end
            end
            ST_KLD: begin
                cnt_lim = LIM_KLD;
                if (cnt_tc) begin
                    state_d  = ST_KGAP;
                    cnt_load = 1'b1;
                end
            end
            ST_KGAP: begin
                state_d  = ST_EXE;
                cnt_load = 1'b1;
            end
            ST_EXE: begin
                cnt_lim = LIM_RUN;
                if (cnt_tc) begin
                    state_d  = ST_DRN;
                    cnt_load = 1'b1;
                end
            end
            ST_DRN: begin
                cnt_lim = LIM_DRN;
                if (cnt_tc) begin
                    state_d  = ST_PWR;
                    cnt_load = 1'b1;
                end
            end
            ST_PWR: begin
                cnt_lim = LIM_RUN;
                if (cnt_tc) begin
`ifdef CORE_CTRL_SFP_EN
                    state_d  = ST_SACC;
`else
                    state_d  = ST_DONE;
`endif
                    cnt_load = 1'b1;
                end
            end
            ST_SACC: begin
                cnt_lim = LIM_RUN;
                if (cnt_tc) begin
                    state_d  = ST_SDIV;
                    cnt_load = 1'b1;
                end
            end
            ST_SDIV: begin
                cnt_lim = LIM_RUN;
                if (cnt_tc) begin
                    state_d  = ST_DONE;
                    cnt_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                cnt_load = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_load = 1'b1;
            end
        endcase
    end

    // Outputs are registered, so the word for the next cycle is decoded from
    // the next state and next count. Stream writes come from the beat
    // accepted this cycle and land one cycle later.
    always_comb begin
        inst_d   = '0;
        mem_in_d = mem_in_q;
        addr_v   = '0;
        if (accept) begin
            if (state_q == ST_QWR)
                inst_d[QWR] = 1'b1;
            else
                inst_d[KWR] = 1'b1;
            inst_d[QK_ADD_LSB +: ADD_W] = cnt[ADD_W-1:0];
            mem_in_d = in_data;
        end
        case (state_d)
            ST_KLD: begin
                if (cnt_nxt >= 1 && cnt_nxt <= COL_C) begin
                    addr_v = cnt_nxt - 1'b1;
                    inst_d[KRD] = 1'b1;
                    inst_d[QK_ADD_LSB +: ADD_W] = addr_v[ADD_W-1:0];
                end
                if (cnt_nxt >= 2) inst_d[LOAD] = 1'b1;
            end
            ST_EXE: begin
                if (cnt_nxt < LQ_C) begin
                    inst_d[QRD] = 1'b1;
                    inst_d[QK_ADD_LSB +: ADD_W] = cnt_nxt[ADD_W-1:0];
                end
                if (cnt_nxt != 0) inst_d[EXEC] = 1'b1;
            end
            ST_PWR: begin
                if (cnt_nxt < LQ_C) inst_d[OFIFO_RD] = 1'b1;
                if (cnt_nxt != 0) begin
                    addr_v = cnt_nxt - 1'b1;
                    inst_d[PWR] = 1'b1;
                    inst_d[P_ADD_LSB +: ADD_W] = addr_v[ADD_W-1:0];
                end
            end
`ifdef CORE_CTRL_SFP_EN
            ST_SACC, ST_SDIV: begin
                if (cnt_nxt < LQ_C) begin
                    inst_d[PRD] = 1'b1;
                    inst_d[P_ADD_LSB +: ADD_W] = cnt_nxt[ADD_W-1:0];
                end
                if (cnt_nxt != 0) begin
                    if (state_d == ST_SACC)
                        inst_d[ACC] = 1'b1;
                    else
                        inst_d[DIV] = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            inst_q     <= '0;
            mem_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            mem_in_q   <= mem_in_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
            in_ready_q <= (state_d == ST_QWR) || (state_d == ST_KWR);
        end
    end

    assign inst     = inst_q;
    assign mem_in   = mem_in_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = in_ready_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: scoreboard bench for core_ctrl. Each cycle the expected
// outputs of the following cycle are pushed when the stimulus is driven and
// popped for comparison on the falling edge.
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    localparam int BW  = 8;
    localparam int PR  = 16;
    localparam int W   = BW * PR;
    localparam int COL = 8;
    localparam int LQ  = 16;
    localparam int DRN = 24;

    localparam int EXE_B  = COL + 3;
    localparam int DRN_B  = EXE_B + LQ + 1;
    localparam int PWR_B  = DRN_B + DRN;
    localparam int SACC_B = PWR_B + LQ + 1;
    localparam int SDIV_B = SACC_B + LQ + 1;
`ifdef CORE_CTRL_SFP_EN
    localparam int DONE_REL = SDIV_B + LQ + 1;
`else
    localparam int DONE_REL = SACC_B;
`endif

    logic              clk = 1'b0;
    logic              reset, start, busy, done, in_valid, in_ready;
    logic [W-1:0]      in_data, mem_in;
    logic [INST_W-1:0] inst;

    core_ctrl #(.bw(BW), .pr(PR), .col(COL), .len_q(LQ), .drain_cyc(DRN)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .mem_in   (mem_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic              busy;
        logic              done;
        logic              rdy;
        logic              wr;
        logic [W-1:0]      data;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected non-stream instruction bits, rel = cycles since KLD entry.
    function automatic logic [INST_W-1:0] fixed_inst(input int rel);
        logic [INST_W-1:0] v;
        int i;
        v = '0;
        if (rel >= 0 && rel <= COL + 1) begin
            if (rel >= 1 && rel <= COL) begin v[KRD] = 1'b1; v[15:12] = 4'(rel - 1); end
            if (rel >= 2) v[LOAD] = 1'b1;
        end else if (rel >= EXE_B && rel < DRN_B) begin
            i = rel - EXE_B;
            if (i < LQ) begin v[QRD] = 1'b1; v[15:12] = 4'(i); end
            if (i >= 1) v[EXEC] = 1'b1;
        end else if (rel >= PWR_B && rel < SACC_B) begin
            i = rel - PWR_B;
            if (i < LQ) v[OFIFO_RD] = 1'b1;
            if (i >= 1) begin v[PWR] = 1'b1; v[11:8] = 4'(i - 1); end
`ifdef CORE_CTRL_SFP_EN
        end else if (rel >= SACC_B && rel < DONE_REL) begin
            i = (rel < SDIV_B) ? rel - SACC_B : rel - SDIV_B;
            if (i < LQ) begin v[PRD] = 1'b1; v[11:8] = 4'(i); end
            if (i >= 1) begin
                if (rel < SDIV_B) v[ACC] = 1'b1;
                else              v[DIV] = 1'b1;
            end
`endif
        end
        return v;
    endfunction

    // One pass: start at k=0; optional input stall, start pulse while busy,
    // or reset abort at the given cycle (negative = unused).
    task automatic run_pass(input int stall_at, input int stall_len, input int busy_start_at,
                            input int abort_at);
        int qb, kb, t_kld, done_c;
        bit rdy_m, acc, finished;
        logic [7:0] b;
        exp_t e, g;
        qb = 0; kb = 0; t_kld = -1; done_c = -1; finished = 1'b0;
        sb.delete();
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (k == abort_at) begin
                reset = 1'b1; start = 1'b0; in_valid = 1'b0;
                #1;
                check($sformatf("abort_inst@%0d", k), W'(inst), '0);
                check($sformatf("abort_busy@%0d", k), W'(busy), '0);
                @(posedge clk); #1;
                check($sformatf("abort_next_inst@%0d", k + 1), W'(inst), '0);
                check($sformatf("abort_next_busy@%0d", k + 1), W'(busy), '0);
                check($sformatf("abort_next_rdy@%0d", k + 1), W'(in_ready), '0);
                reset = 1'b0;
                finished = 1'b1;
                break;
            end
            start    = (k == 0) || (k == busy_start_at);
            in_valid = !(k >= stall_at && k < stall_at + stall_len);
            rdy_m    = (k >= 1) && (t_kld < 0);
            acc      = in_valid && rdy_m;
            e = '0;
            if (acc) begin
                if (qb < LQ) begin
                    b = 8'(qb + 1);
                    e.inst[QWR] = 1'b1;
                    e.inst[15:12] = 4'(qb);
                    qb++;
                end else begin
                    b = 8'(8'hA0 + kb);
                    e.inst[KWR] = 1'b1;
                    e.inst[15:12] = 4'(kb);
                    kb++;
                    if (kb == COL) t_kld = k + 1;
                end
                in_data = {PR{b}};
                e.wr    = 1'b1;
                e.data  = {PR{b}};
            end else begin
                in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (t_kld >= 0) done_c = t_kld + DONE_REL;
            if (t_kld >= 0 && k + 1 >= t_kld) e.inst = e.inst | fixed_inst(k + 1 - t_kld);
            e.busy = (done_c < 0) || (k + 1 <= done_c);
            e.done = (k + 1 == done_c);
            e.rdy  = (t_kld < 0);
            sb.push_back(e);
            @(negedge clk);
            if (k == 0) begin
                check("idle_busy@0", W'(busy), '0);
            end else begin
                g = sb.pop_front();
                check($sformatf("inst@%0d", k), W'(inst), W'(g.inst));
                check($sformatf("busy@%0d", k), W'(busy), W'(g.busy));
                check($sformatf("done@%0d", k), W'(done), W'(g.done));
                check($sformatf("in_ready@%0d", k), W'(in_ready), W'(g.rdy));
                if (g.wr) check($sformatf("mem_in@%0d", k), mem_in, g.data);
            end
            if (done_c >= 0 && k >= done_c + 2) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        check("pass_completed", W'(finished), W'(1));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", W'(inst), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_in_ready", W'(in_ready), '0);
        check("rst_mem_in", mem_in, '0);
        reset = 1'b0;

        run_pass(-10, 0, -1, -1);   // baseline
        run_pass(6, 3, -1, -1);     // stall after five Q beats
        run_pass(-10, 0, 50, -1);   // start while busy ignored
        run_pass(-10, 0, -1, 40);   // reset mid-EXE
        run_pass(-10, 0, -1, -1);   // full pass after reset

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
